datapath: RTL and testbench

DATAPATH -- requirements
Module: datapath

---
 rtl/datapath_if.sv | 9 +
 rtl/datapath.sv | 147 ++++++++++++++
 tb/tb_datapath.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/datapath_if.sv
// Memory-side bus of the datapath: address/write-data out, read-data in.
interface datapath_if;
   logic [31:0] iMemData;
   logic [31:0] oMemAddr;
   logic [31:0] oMemData;

   modport master (input iMemData, output oMemAddr, output oMemData);
   modport slave  (output iMemData, input oMemAddr, input oMemData);
endinterface

// File: rtl/datapath.sv
// Single-bus CPU datapath: 16x32 register file, operand latches RA/RB,
// 64-bit ALU result latches RZH/RZL, store/write-back latches RAS/RWB and PC.
module datapath (
   input  logic        iClk,
   input  logic        nRst,
   datapath_if.master  mem,
   input  logic        iPC_nRst,
   input  logic        iPC_en,
   input  logic        iPC_jmp,
   input  logic        iPC_loadRA,
   input  logic        iPC_loadImm,
   input  logic        iRF_Write,
   input  logic [3:0]  iRF_AddrA,
   input  logic [3:0]  iRF_AddrB,
   input  logic [3:0]  iRF_AddrC,
   input  logic        iRWB_en,
   input  logic [3:0]  iALU_Ctrl,
   input  logic        iRA_en,
   input  logic        iRB_en,
   input  logic        iRZH_en,
   input  logic        iRZL_en,
   input  logic        iRAS_en,
   output logic        oJ_zero,
   output logic        oJ_nZero,
   output logic        oJ_pos,
   output logic        oJ_neg,
   output logic        oALU_neg,
   output logic        oALU_zero,
   input  logic        iMUX_BIS,
   input  logic        iMUX_RZHS,
   input  logic        iMUX_WBM,
   input  logic        iMUX_WBP,
   input  logic        iMUX_MAP,
   input  logic        iMUX_ASS,
   input  logic [31:0] iImm32
);

   logic [31:0] rf [16];
   logic [31:0] pc, ra, rb, rzh, rzl, ras, rwb;
   logic [31:0] port_a, port_b, z;
   logic [31:0] alu_hi, alu_lo;
   logic [63:0] mul_p;
   logic [4:0]  sh;

   assign port_a = rf[iRF_AddrA];
   assign port_b = rf[iRF_AddrB];
   assign z      = iMUX_RZHS ? rzh : rzl;
   assign sh     = rb[4:0];

   assign mem.oMemAddr = iMUX_MAP ? pc : z;
   assign mem.oMemData = ras;

   assign oJ_zero   = (port_a == '0);
   assign oJ_nZero  = (port_a != '0);
   assign oJ_pos    = !port_a[31] && (port_a != '0);
   assign oJ_neg    = port_a[31];
   assign oALU_zero = (alu_lo == '0);
   assign oALU_neg  = alu_lo[31];

   assign mul_p = $signed({{32{ra[31]}}, ra}) * $signed({{32{rb[31]}}, rb});

   // ALU: 64-bit {hi,lo}; divide done at 33 bits so MIN/-1 cannot overflow
   always_comb begin
      alu_hi = '0;
      alu_lo = '0;
      case (iALU_Ctrl)
         4'd0:  alu_lo = ra + rb;
         4'd1:  alu_lo = ra - rb;
         4'd2:  alu_lo = ra & rb;
         4'd3:  alu_lo = ra | rb;
         4'd4:  alu_lo = ra >> sh;
         4'd5:  alu_lo = $signed(ra) >>> sh;
         4'd6:  alu_lo = ra << sh;
         4'd7:  alu_lo = 32'({ra, ra} >> sh);
         4'd8:  alu_lo = 32'({ra, ra} >> (6'd32 - {1'b0, sh}));
         4'd9:  {alu_hi, alu_lo} = mul_p;
         4'd10: begin
            if (rb == '0) begin
               alu_lo = '1;
               alu_hi = ra;
            end else begin
               alu_lo = 32'($signed({ra[31], ra}) / $signed({rb[31], rb}));
               alu_hi = 32'($signed({ra[31], ra}) % $signed({rb[31], rb}));
            end
         end
         4'd11: alu_lo = 32'd0 - rb;
         4'd12: alu_lo = ~rb;
         default: alu_lo = rb;
      endcase
   end

   // register file write port C (reads above see the pre-edge contents)
   always_ff @(posedge iClk or posedge nRst) begin
      if (nRst) begin
         for (int i = 0; i < 16; i++) rf[i] <= '0;
      end else if (iRF_Write) begin
         rf[iRF_AddrC] <= rwb;
      end
   end

   // ALU operand latches
   always_ff @(posedge iClk or posedge nRst) begin
      if (nRst) begin
         ra <= '0;
         rb <= '0;
      end else begin
         if (iRA_en) ra <= port_a;
         if (iRB_en) rb <= iMUX_BIS ? iImm32 : port_b;
      end
   end

   // ALU result latches
   always_ff @(posedge iClk or posedge nRst) begin
      if (nRst) begin
         rzh <= '0;
         rzl <= '0;
      end else begin
         if (iRZH_en) rzh <= alu_hi;
         if (iRZL_en) rzl <= alu_lo;
      end
   end

   // store-data and write-back latches
   always_ff @(posedge iClk or posedge nRst) begin
      if (nRst) begin
         ras <= '0;
         rwb <= '0;
      end else begin
         if (iRAS_en) ras <= iMUX_ASS ? z : port_b;
         if (iRWB_en) rwb <= iMUX_WBM ? mem.iMemData : (iMUX_WBP ? pc : z);
      end
   end

   // program counter: sync clear > load RA > relative jump > increment
   always_ff @(posedge iClk or posedge nRst) begin
      if (nRst) begin
         pc <= '0;
      end else if (!iPC_nRst) begin
         pc <= '0;
      end else if (iPC_en) begin
         if (iPC_loadRA)                  pc <= ra;
         else if (iPC_loadImm && iPC_jmp) pc <= pc + 32'd1 + iImm32;
         else                             pc <= pc + 32'd1;
      end
   end

endmodule

// File: tb/tb_datapath.sv
// Scoreboarded bench: stimulus pushes expectations from a behavioural model,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_datapath;

   logic        iClk = 1'b0;
   logic        nRst;
   logic        iPC_nRst, iPC_en, iPC_jmp, iPC_loadRA, iPC_loadImm;
   logic        iRF_Write, iRWB_en;
   logic [3:0]  iRF_AddrA, iRF_AddrB, iRF_AddrC, iALU_Ctrl;
   logic        iRA_en, iRB_en, iRZH_en, iRZL_en, iRAS_en;
   logic        oJ_zero, oJ_nZero, oJ_pos, oJ_neg, oALU_neg, oALU_zero;
   logic        iMUX_BIS, iMUX_RZHS, iMUX_WBM, iMUX_WBP, iMUX_MAP, iMUX_ASS;
   logic [31:0] iImm32;

   datapath_if mem_if ();

   datapath dut (
      .iClk(iClk), .nRst(nRst), .mem(mem_if),
      .iPC_nRst(iPC_nRst), .iPC_en(iPC_en), .iPC_jmp(iPC_jmp),
      .iPC_loadRA(iPC_loadRA), .iPC_loadImm(iPC_loadImm),
      .iRF_Write(iRF_Write), .iRF_AddrA(iRF_AddrA), .iRF_AddrB(iRF_AddrB),
      .iRF_AddrC(iRF_AddrC), .iRWB_en(iRWB_en), .iALU_Ctrl(iALU_Ctrl),
      .iRA_en(iRA_en), .iRB_en(iRB_en), .iRZH_en(iRZH_en), .iRZL_en(iRZL_en),
      .iRAS_en(iRAS_en), .oJ_zero(oJ_zero), .oJ_nZero(oJ_nZero), .oJ_pos(oJ_pos),
      .oJ_neg(oJ_neg), .oALU_neg(oALU_neg), .oALU_zero(oALU_zero),
      .iMUX_BIS(iMUX_BIS), .iMUX_RZHS(iMUX_RZHS), .iMUX_WBM(iMUX_WBM),
      .iMUX_WBP(iMUX_WBP), .iMUX_MAP(iMUX_MAP), .iMUX_ASS(iMUX_ASS),
      .iImm32(iImm32)
   );

   always #5 iClk = ~iClk;

   typedef struct {
      logic        rst, pc_nrst, pc_en, pc_jmp, pc_ra, pc_imm, rf_w, rwb_en;
      logic [3:0]  a, b, c, alu;
      logic        ra_en, rb_en, rzh_en, rzl_en, ras_en;
      logic        bis, rzhs, wbm, wbp, map, ass;
      logic [31:0] imm, mem;
   } ctl_t;

   // kind: 0 = all outputs from model, 1 = addr const, 2 = data const, 3 = flags const
   typedef struct {
      int          cyc;
      int          kind;
      logic [31:0] addr, data;
      logic [5:0]  flags;
      string       name;
   } exp_t;

   exp_t sbq[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_err = 0;

   // behavioural machine state
   logic [31:0] m_rf [16];
   logic [31:0] m_pc, m_ra, m_rb, m_rzh, m_rzl, m_ras, m_rwb;

   function automatic logic [63:0] m_alu(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] op);
      longint sa, sb, q, rm;
      int     n;
      logic [31:0] r;
      sa = $signed(a);
      sb = $signed(b);
      n  = int'(b[4:0]);
      r  = a;
      case (op)
         4'd0:  return {32'd0, a + b};
         4'd1:  return {32'd0, a - b};
         4'd2:  return {32'd0, a & b};
         4'd3:  return {32'd0, a | b};
         4'd4:  return {32'd0, a >> n};
         4'd5:  begin q = sa >>> n; return {32'd0, q[31:0]}; end
         4'd6:  return {32'd0, a << n};
         4'd7:  begin repeat (n) r = {r[0], r[31:1]}; return {32'd0, r}; end
         4'd8:  begin repeat (n) r = {r[30:0], r[31]}; return {32'd0, r}; end
         4'd9:  begin q = sa * sb; return q; end
         4'd10: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            q  = sa / sb;
            rm = sa % sb;
            return {rm[31:0], q[31:0]};
         end
         4'd11: return {32'd0, 32'd0 - b};
         4'd12: return {32'd0, ~b};
         default: return {32'd0, b};
      endcase
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 16; i++) m_rf[i] = '0;
      {m_pc, m_ra, m_rb, m_rzh, m_rzl, m_ras, m_rwb} = '0;
   endtask

   function automatic exp_t m_outputs(input ctl_t c);
      exp_t e;
      logic [31:0] av, z;
      logic [63:0] r;
      av = m_rf[c.a];
      r  = m_alu(m_ra, m_rb, c.alu);
      z  = c.rzhs ? m_rzh : m_rzl;
      e.addr  = c.map ? m_pc : z;
      e.data  = m_ras;
      e.flags = {av == 0, av != 0, !av[31] && av != 0, av[31], r[31], r[31:0] == 0};
      e.kind  = 0;
      e.cyc   = cyc;
      e.name  = "cycle";
      return e;
   endfunction

   task automatic m_clock(input ctl_t c);
      logic [31:0] av, bv, z, npc;
      logic [63:0] r;
      av = m_rf[c.a];
      bv = m_rf[c.b];
      r  = m_alu(m_ra, m_rb, c.alu);
      z  = c.rzhs ? m_rzh : m_rzl;
      npc = m_pc;
      if (!c.pc_nrst) npc = 0;
      else if (c.pc_en) begin
         if (c.pc_ra)                    npc = m_ra;
         else if (c.pc_imm && c.pc_jmp)  npc = m_pc + 1 + c.imm;
         else                            npc = m_pc + 1;
      end
      if (c.rf_w)   m_rf[c.c] = m_rwb;
      if (c.ra_en)  m_ra  = av;
      if (c.rb_en)  m_rb  = c.bis ? c.imm : bv;
      if (c.rzh_en) m_rzh = r[63:32];
      if (c.rzl_en) m_rzl = r[31:0];
      if (c.ras_en) m_ras = c.ass ? z : bv;
      if (c.rwb_en) m_rwb = c.wbm ? c.mem : (c.wbp ? m_pc : z);
      m_pc = npc;
   endtask

   function automatic ctl_t idle();
      ctl_t c;
      c = '{default: '0};
      c.pc_nrst = 1'b1;
      return c;
   endfunction

   function automatic ctl_t rnd();
      ctl_t c;
      c.rst = ($urandom_range(0, 63) == 0);
      c.pc_nrst = ($urandom_range(0, 15) != 0);
      {c.pc_en, c.pc_jmp, c.pc_ra, c.pc_imm, c.rf_w, c.rwb_en} = 6'($urandom);
      {c.a, c.b, c.c, c.alu} = 16'($urandom);
      {c.ra_en, c.rb_en, c.rzh_en, c.rzl_en, c.ras_en} = 5'($urandom);
      {c.bis, c.rzhs, c.wbm, c.wbp, c.map, c.ass} = 6'($urandom);
      c.imm = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      c.mem = $urandom;
      return c;
   endfunction

   task automatic drive(input ctl_t c);
      nRst = c.rst;
      iPC_nRst = c.pc_nrst; iPC_en = c.pc_en; iPC_jmp = c.pc_jmp;
      iPC_loadRA = c.pc_ra; iPC_loadImm = c.pc_imm;
      iRF_Write = c.rf_w; iRWB_en = c.rwb_en;
      iRF_AddrA = c.a; iRF_AddrB = c.b; iRF_AddrC = c.c; iALU_Ctrl = c.alu;
      iRA_en = c.ra_en; iRB_en = c.rb_en; iRZH_en = c.rzh_en;
      iRZL_en = c.rzl_en; iRAS_en = c.ras_en;
      iMUX_BIS = c.bis; iMUX_RZHS = c.rzhs; iMUX_WBM = c.wbm;
      iMUX_WBP = c.wbp; iMUX_MAP = c.map; iMUX_ASS = c.ass;
      iImm32 = c.imm;
      mem_if.iMemData = c.mem;
   endtask

   // one clock of stimulus, entered just after a rising edge
   task automatic step(input ctl_t c, input int kind, input logic [31:0] cv, input string nm);
      exp_t e;
      drive(c);
      if (c.rst) m_reset();
      e = m_outputs(c);
      sbq.push_back(e);
      if (kind != 0) begin
         e.kind = kind; e.addr = cv; e.data = cv; e.flags = cv[5:0]; e.name = nm;
         sbq.push_back(e);
      end
      @(posedge iClk);
      if (!c.rst) m_clock(c);
      #1 cyc++;
   endtask

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, got, want);
      end
   endtask

   // monitor: compare every expectation due in the current cycle
   always @(negedge iClk) begin
      logic [5:0] fl;
      exp_t e;
      fl = {oJ_zero, oJ_nZero, oJ_pos, oJ_neg, oALU_neg, oALU_zero};
      while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
         e = sbq.pop_front();
         case (e.kind)
            0: begin
               chk("addr",  mem_if.oMemAddr, e.addr);
               chk("data",  mem_if.oMemData, e.data);
               chk("flags", {26'd0, fl}, {26'd0, e.flags});
            end
            1: chk(e.name, mem_if.oMemAddr, e.addr);
            2: chk(e.name, mem_if.oMemData, e.data);
            default: chk(e.name, {26'd0, fl}, {26'd0, e.flags});
         endcase
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      ctl_t c;
      c = idle(); c.rst = 1'b1;
      drive(c);
      m_reset();
      @(posedge iClk); #1;

      // reset state
      c = idle(); c.rst = 1; step(c, 1, 32'd0, "rst_addr");
      c = idle(); c.rst = 1; step(c, 2, 32'd0, "rst_data");
      c = idle(); c.rst = 1; step(c, 3, 32'b100001, "rst_flags");

      // fetch and relative jump
      c = idle(); c.pc_en = 1; c.map = 1; step(c, 1, 32'd0, "fetch_pc0");
      c = idle(); c.pc_en = 1; c.map = 1; c.pc_jmp = 1; c.pc_imm = 1; c.imm = 5;
      step(c, 1, 32'd1, "fetch_pc1");
      c = idle(); c.map = 1; step(c, 1, 32'd7, "jump_pc7");

      // R3=0x22, R7=0x24, R4=R3+R7
      c = idle(); c.mem = 32'h22; c.rwb_en = 1; c.wbm = 1; step(c, 0, 0, "");
      c = idle(); c.rf_w = 1; c.c = 3; c.mem = 32'h24; c.rwb_en = 1; c.wbm = 1; step(c, 0, 0, "");
      c = idle(); c.rf_w = 1; c.c = 7; step(c, 0, 0, "");
      c = idle(); c.a = 3; c.ra_en = 1; c.b = 7; c.rb_en = 1; step(c, 0, 0, "");
      c = idle(); c.alu = 0; c.rzl_en = 1; step(c, 0, 0, "");
      c = idle(); c.rwb_en = 1; step(c, 0, 0, "");
      c = idle(); c.rf_w = 1; c.c = 4; step(c, 0, 0, "");
      c = idle(); c.b = 4; c.ras_en = 1; step(c, 0, 0, "");
      c = idle(); step(c, 2, 32'h46, "r4_sum");

      // immediate operand, negative result
      c = idle(); c.a = 0; c.ra_en = 1; c.rb_en = 1; c.bis = 1; c.imm = 32'hFFFF_FFFF;
      step(c, 0, 0, "");
      c = idle(); c.rzl_en = 1; step(c, 3, 32'b100010, "add_neg_flags");
      c = idle(); step(c, 1, 32'hFFFF_FFFF, "add_neg_rzl");

      // MUL 0x10000^2 and DIV 7/0
      c = idle(); c.mem = 32'h1_0000; c.rwb_en = 1; c.wbm = 1; step(c, 0, 0, "");
      c = idle(); c.rf_w = 1; c.c = 5; c.mem = 32'd7; c.rwb_en = 1; c.wbm = 1; step(c, 0, 0, "");
      c = idle(); c.rf_w = 1; c.c = 6; step(c, 0, 0, "");
      c = idle(); c.a = 5; c.ra_en = 1; c.rb_en = 1; c.bis = 1; c.imm = 32'h1_0000;
      step(c, 0, 0, "");
      c = idle(); c.alu = 9; c.rzh_en = 1; c.rzl_en = 1; step(c, 0, 0, "");
      c = idle(); c.rzhs = 1; step(c, 1, 32'd1, "mul_hi");
      c = idle(); step(c, 1, 32'd0, "mul_lo");
      c = idle(); c.a = 6; c.ra_en = 1; c.rb_en = 1; c.bis = 1; c.imm = 32'd0;
      step(c, 0, 0, "");
      c = idle(); c.alu = 10; c.rzh_en = 1; c.rzl_en = 1; step(c, 0, 0, "");
      c = idle(); step(c, 1, 32'hFFFF_FFFF, "div0_lo");
      c = idle(); c.rzhs = 1; step(c, 1, 32'd7, "div0_hi");

      // asynchronous reset mid-sequence with R3 loaded
      c = idle(); c.a = 3; step(c, 3, 32'b011000, "r3_flags");
      c = idle(); c.rst = 1; c.a = 3; step(c, 3, 32'b100001, "rst_r3_zero");
      c = idle(); c.rst = 1; c.map = 1; step(c, 1, 32'd0, "rst_pc");
      c = idle(); c.rst = 1; step(c, 1, 32'd0, "rst_rzl");

      // randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         c = rnd();
         step(c, 0, 0, "");
      end

      @(negedge iClk); #1;
      n_checks++;
      if (sbq.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d expectations left, expected 0", sbq.size());
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
